mem_refill_arbiter: RTL and testbench

- Shares the single 128-bit line-wide main-memory port between the instruction-cache refill path and the data-cache refill/write-back path.
- Accepts one line transaction at a time, sequences the fixed-latency memory access with an internal counter, and returns the 128-bit line to the winning requester with a one-cycle done pulse.
- Sits between the fetch/memory-stage caches and main memory.

---
 rtl/mem_refill_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_refill_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_refill_arbiter.sv
// rtl/mem_refill_arbiter.sv - shares one line-wide memory port between I-cache refill and D-cache refill/write-back
// Optional: define ARB_ROUND_ROBIN_EN for round-robin conflict arbitration (default: D-cache fixed priority).
module mem_refill_arbiter #(
    parameter int LATENCY = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic [31:0]  i_addr,
    output logic         i_done,
    output logic [127:0] i_line,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [31:0]  d_addr,
    input  logic [127:0] d_wdata,
    output logic         d_done,
    output logic [127:0] d_line,
    output logic         mem_en,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    output logic         busy,
    output logic         owner
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    logic [1:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         owner_q, owner_d;
    logic         we_q, we_d;
    logic [31:0]  addr_q, addr_d;
    logic [127:0] wdata_q, wdata_d;
    logic [127:0] i_line_q, i_line_d;
    logic [127:0] d_line_q, d_line_d;
    logic         win_dcache;

    // owner_q doubles as the round-robin pointer: it always holds the last grant.
`ifdef ARB_ROUND_ROBIN_EN
    assign win_dcache = d_req && (!i_req || !owner_q);
`else
    assign win_dcache = d_req;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        i_line_d = i_line_q;
        d_line_d = d_line_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    state_d = ST_BUSY;
                    cnt_d   = 4'd0;
                    owner_d = win_dcache;
                    we_d    = win_dcache && d_we;
                    addr_d  = win_dcache ? {d_addr[31:2], 2'b00} : {i_addr[31:2], 2'b00};
                    wdata_d = win_dcache ? d_wdata : 128'd0;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        if (owner_q) begin
                            d_line_d = mem_rdata;
                        end else begin
                            i_line_d = mem_rdata;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            owner_q  <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 128'd0;
            i_line_q <= 128'd0;
            d_line_q <= 128'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            i_line_q <= i_line_d;
            d_line_q <= d_line_d;
        end
    end

    assign mem_en    = (state_q == ST_BUSY);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign i_done    = (state_q == ST_DONE) && !owner_q;
    assign d_done    = (state_q == ST_DONE) && owner_q;
    assign i_line    = i_line_q;
    assign d_line    = d_line_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb/tb_mem_refill_arbiter.sv - self-checking bench for mem_refill_arbiter
module tb_mem_refill_arbiter;

    localparam int L = 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req, d_req, d_we;
    logic [31:0]  i_addr, d_addr;
    logic [127:0] d_wdata, mem_rdata;
    logic         i_done, d_done, mem_en, mem_we, busy, owner;
    logic [127:0] i_line, d_line, mem_wdata;
    logic [31:0]  mem_addr;

    int vecs = 0;
    int errs = 0;
    logic [127:0] exp_i_line, exp_d_line;

    mem_refill_arbiter #(.LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_line(i_line),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_line(d_line),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick; tick;
        vecs++;
        if ({mem_en, mem_we, busy, i_done, d_done, owner} !== 6'b000001) begin
            errs++; $display("FAIL reset_ctrl got %b required 000001", {mem_en, mem_we, busy, i_done, d_done, owner});
        end
        vecs++;
        if (mem_addr !== 32'd0 || mem_wdata !== 128'd0) begin
            errs++; $display("FAIL reset_mem addr=%h wdata=%h required 0", mem_addr, mem_wdata);
        end
        vecs++;
        if (i_line !== 128'd0 || d_line !== 128'd0) begin
            errs++; $display("FAIL reset_lines i=%h d=%h required 0", i_line, d_line);
        end
        rst = 1'b1;
        exp_i_line = '0; exp_d_line = '0;
        tick;
    endtask

    task automatic test_simultaneous;
        int i_at = -1;
        int d_at = -1;
        bit both = 1'b0;
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        mem_rdata = r;
        i_req = 1'b1; i_addr = 32'h0000_1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        for (int k = 0; k < 24; k++) begin
            tick;
            if (i_done && d_done) both = 1'b1;
            if (i_done) begin i_at = k; i_req = 1'b0; end
            if (d_done) begin d_at = k; d_req = 1'b0; end
        end
        i_req = 1'b0; d_req = 1'b0;
        vecs++;
        if (i_at !== (RR ? L : 2 * L + 2)) begin
            errs++; $display("FAIL sim_i_done cycle got %0d required %0d", i_at, RR ? L : 2 * L + 2);
        end
        vecs++;
        if (d_at !== (RR ? 2 * L + 2 : L)) begin
            errs++; $display("FAIL sim_d_done cycle got %0d required %0d", d_at, RR ? 2 * L + 2 : L);
        end
        vecs++;
        if (both) begin
            errs++; $display("FAIL sim_both_done got 1 required 0");
        end
        exp_i_line = r; exp_d_line = r;
        vecs++;
        if (i_line !== exp_i_line || d_line !== exp_d_line) begin
            errs++; $display("FAIL sim_lines i=%h d=%h required %h", i_line, d_line, r);
        end
    endtask

    task automatic test_single_iread;
        int en_cnt = 0;
        int i_at = -1;
        int dn_cnt = 0;
        mem_rdata = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000;
        i_req = 1'b1; i_addr = 32'h0000_0107;
        for (int k = 0; k < L + 2; k++) begin
            tick;
            if (k == 0) begin
                vecs++;
                if (mem_addr !== 32'h0000_0104 || mem_we !== 1'b0) begin
                    errs++; $display("FAIL iread_addr got %h we=%b required 00000104 we=0", mem_addr, mem_we);
                end
            end
            if (mem_en) en_cnt++;
            if (i_done || d_done) dn_cnt++;
            if (i_done) begin i_at = k; i_req = 1'b0; end
        end
        i_req = 1'b0;
        vecs++;
        if (en_cnt !== L) begin
            errs++; $display("FAIL iread_en_cycles got %0d required %0d", en_cnt, L);
        end
        vecs++;
        if (i_at !== L || dn_cnt !== 1) begin
            errs++; $display("FAIL iread_done got cycle %0d count %0d required cycle %0d count 1", i_at, dn_cnt, L);
        end
        exp_i_line = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000;
        vecs++;
        if (i_line !== exp_i_line || d_line !== exp_d_line) begin
            errs++; $display("FAIL iread_lines i=%h d=%h required i=%h d=%h", i_line, d_line, exp_i_line, exp_d_line);
        end
    endtask

    task automatic test_dwrite;
        int wr_cnt = 0;
        int d_at = -1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = {16{8'hA5}};
        for (int k = 0; k < L + 2; k++) begin
            tick;
            if (mem_en && mem_we && mem_wdata === {16{8'hA5}} && mem_addr === 32'h0000_0200) wr_cnt++;
            if (d_done) begin d_at = k; d_req = 1'b0; end
        end
        d_req = 1'b0; d_we = 1'b0;
        vecs++;
        if (wr_cnt !== L) begin
            errs++; $display("FAIL dwrite_cycles got %0d required %0d", wr_cnt, L);
        end
        vecs++;
        if (d_at !== L) begin
            errs++; $display("FAIL dwrite_done cycle got %0d required %0d", d_at, L);
        end
        vecs++;
        if (d_line !== exp_d_line || i_line !== exp_i_line) begin
            errs++; $display("FAIL dwrite_lines i=%h d=%h required i=%h d=%h", i_line, d_line, exp_i_line, exp_d_line);
        end
    endtask

    task automatic test_drop_in_busy;
        int i_at = -1;
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        mem_rdata = r;
        i_req = 1'b1; i_addr = $urandom;
        for (int k = 0; k < L + 2; k++) begin
            tick;
            if (k == 3) i_req = 1'b0;
            if (i_done) i_at = k;
        end
        vecs++;
        if (i_at !== L) begin
            errs++; $display("FAIL drop_done cycle got %0d required %0d", i_at, L);
        end
        vecs++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            errs++; $display("FAIL drop_idle busy=%b mem_en=%b required 0 0", busy, mem_en);
        end
        exp_i_line = r;
        vecs++;
        if (i_line !== exp_i_line) begin
            errs++; $display("FAIL drop_line got %h required %h", i_line, exp_i_line);
        end
    endtask

    task automatic test_reset_mid;
        int i_at = -1;
        bit spurious = 1'b0;
        logic [127:0] r;
        i_req = 1'b1; i_addr = 32'h0000_3000;
        for (int k = 0; k < 4; k++) tick;
        rst = 1'b0;
        #1;
        vecs++;
        if ({mem_en, mem_we, busy, i_done, d_done, owner} !== 6'b000001) begin
            errs++; $display("FAIL rstmid_ctrl got %b required 000001", {mem_en, mem_we, busy, i_done, d_done, owner});
        end
        vecs++;
        if (mem_addr !== 32'd0 || mem_wdata !== 128'd0 || i_line !== 128'd0 || d_line !== 128'd0) begin
            errs++; $display("FAIL rstmid_data addr=%h wdata=%h i=%h d=%h required 0", mem_addr, mem_wdata, i_line, d_line);
        end
        i_req = 1'b0;
        for (int k = 0; k < L + 2; k++) begin
            tick;
            if (i_done || d_done) spurious = 1'b1;
        end
        rst = 1'b1;
        vecs++;
        if (spurious) begin
            errs++; $display("FAIL rstmid_spurious_done got 1 required 0");
        end
        exp_i_line = '0; exp_d_line = '0;
        r = {$urandom, $urandom, $urandom, $urandom};
        mem_rdata = r;
        i_req = 1'b1; i_addr = 32'h0000_4004;
        for (int k = 0; k < L + 2; k++) begin
            tick;
            if (i_done) begin i_at = k; i_req = 1'b0; end
        end
        i_req = 1'b0;
        exp_i_line = r;
        vecs++;
        if (i_at !== L || i_line !== exp_i_line) begin
            errs++; $display("FAIL rstmid_recover cycle %0d line %h required cycle %0d line %h", i_at, i_line, L, exp_i_line);
        end
    endtask

    // Transaction-level reference: a grant at edge me occupies the port for L cycles,
    // pulses done on the cycle after, and the next grant cannot happen before me+L+2.
    task automatic test_random;
        bit have = 1'b0;
        int me = 0;
        bit mlast = 1'b1;
        bit mwe = 1'b0;
        bit win, en, dn;
        logic [31:0]  maddr = '0;
        logic [127:0] mwd = '0;
        logic [127:0] mi = '0;
        logic [127:0] md = '0;
        logic [5:0]   exp_ctrl;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick;
        rst = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            tick;
            if (have && t == me + L && !mwe) begin
                if (mlast) md = mem_rdata;
                else mi = mem_rdata;
            end
            if ((!have || t >= me + L + 2) && (i_req || d_req)) begin
                if (i_req && d_req) win = RR ? (mlast == 1'b0) : 1'b1;
                else win = d_req;
                have = 1'b1; me = t; mlast = win;
                mwe = win && d_we;
                maddr = win ? {d_addr[31:2], 2'b00} : {i_addr[31:2], 2'b00};
                mwd = d_wdata;
            end
            en = have && t < me + L;
            dn = have && t == me + L;
            exp_ctrl = {en, have && t <= me + L, dn && !mlast, dn && mlast, en && mwe, mlast};
            vecs++;
            if ({mem_en, busy, i_done, d_done, mem_we, owner} !== exp_ctrl) begin
                errs++; $display("FAIL rand_ctrl t=%0d got %b required %b", t, {mem_en, busy, i_done, d_done, mem_we, owner}, exp_ctrl);
            end
            if (en) begin
                vecs++;
                if (mem_addr !== maddr) begin
                    errs++; $display("FAIL rand_addr t=%0d got %h required %h", t, mem_addr, maddr);
                end
            end
            if (en && mwe) begin
                vecs++;
                if (mem_wdata !== mwd) begin
                    errs++; $display("FAIL rand_wdata t=%0d got %h required %h", t, mem_wdata, mwd);
                end
            end
            vecs++;
            if (i_line !== mi || d_line !== md) begin
                errs++; $display("FAIL rand_lines t=%0d i=%h d=%h required i=%h d=%h", t, i_line, d_line, mi, md);
            end
            if (dn && !mlast) i_req = 1'b0;
            else if (!i_req && $urandom_range(3) == 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (dn && mlast) d_req = 1'b0;
            else if (!d_req && $urandom_range(3) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = $urandom;
                d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        test_reset;
        test_simultaneous;
        test_single_iread;
        test_dwrite;
        test_drop_in_busy;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
